arm_memory: RTL and testbench

// - Dual-port unified word memory for the ARM CPU core. Port 0 serves instruction fetch; port 1 serves load/store.
// - Writes are synchronous. Reads are combinational. Each port raises an exception flag on an illegal access.
// - Sits between the pipeline's fetch/memory stages and acts as the whole system RAM for simulation.

---
 rtl/arm_memory.sv | 50 +++++
 tb/tb_arm_memory.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/arm_memory.sv
// Dual-port unified word memory: port 0 fetch, port 1 load/store.
// Combinational reads, synchronous writes, per-port illegal-access flags.
module arm_memory #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [0:1][31:0]       addr,
  input  logic [0:1][DATA_W-1:0] data_in,
  input  logic [0:1]             we,
  output logic [0:1]             excpt,
  output logic [0:1][DATA_W-1:0] data_out
);

  localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  logic [DATA_W-1:0]       mem_q [MEM_WORDS];
  logic [0:1]              legal;
  logic [0:1][IDX_W-1:0]   idx;
  logic [0:1]              wr_en;

  // The if/else form makes an unknown address fall through to "illegal".
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      legal[p] = 1'b0;
      if ((addr[p][1:0] == 2'b00) && (addr[p] < ADDR_LIMIT)) legal[p] = 1'b1;
      idx[p]      = addr[p][IDX_W+1:2];
      excpt[p]    = ~legal[p];
      data_out[p] = '0;
      if (legal[p]) data_out[p] = mem_q[idx[p]];
      wr_en[p]    = 1'b0;
      if (we[p] && legal[p]) wr_en[p] = 1'b1;
    end
  end

  // Port 0 wins a same-word collision, so port 1 is suppressed in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en[1] && !(wr_en[0] && (idx[0] == idx[1])))
        mem_q[idx[1]] <= data_in[1];
      if (wr_en[0])
        mem_q[idx[0]] <= data_in[0];
    end
  end

endmodule

// File: tb/tb_arm_memory.sv
// Bench for arm_memory: directed scenarios then random traffic against a word-array model.
module tb_arm_memory;

  localparam int unsigned WORDS = 1024;

  logic             clk;
  logic             rst_n;
  logic [0:1][31:0] addr;
  logic [0:1][31:0] data_in;
  logic [0:1]       we;
  logic [0:1]       excpt;
  logic [0:1][31:0] data_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [WORDS];

  arm_memory #(.MEM_WORDS(WORDS), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .excpt    (excpt),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * WORDS);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (!is_legal(a)) return 32'h0;
    return model[a / 4];
  endfunction

  task automatic check_port(input int p, input logic [31:0] a, input string tag);
    logic        exp_x;
    logic [31:0] exp_d;
    exp_x = !is_legal(a);
    exp_d = exp_read(a);
    checks++;
    assert (excpt[p] === exp_x) else begin
      failures++;
      $error("FAIL %s excpt[%0d] addr=%h got=%b want=%b", tag, p, a, excpt[p], exp_x);
    end
    checks++;
    assert (data_out[p] === exp_d) else begin
      failures++;
      $error("FAIL %s data_out[%0d] addr=%h got=%h want=%h", tag, p, a, data_out[p], exp_d);
    end
  endtask

  // One cycle: drive on negedge, check reads (old contents), then commit to model at posedge.
  task automatic step(input logic [31:0] a0, input logic [31:0] d0, input logic w0,
                      input logic [31:0] a1, input logic [31:0] d1, input logic w1,
                      input string tag);
    @(negedge clk);
    addr[0] = a0; data_in[0] = d0; we[0] = w0;
    addr[1] = a1; data_in[1] = d1; we[1] = w1;
    #1;
    check_port(0, a0, tag);
    check_port(1, a1, tag);
    @(posedge clk);
    if (rst_n) begin
      if (w1 && is_legal(a1)) model[a1 / 4] = d1;
      if (w0 && is_legal(a0)) model[a0 / 4] = d0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 14) return 32'($urandom_range(0, 15)) * 4;
    if (r < 16) return 32'($urandom_range(WORDS - 4, WORDS - 1)) * 4;
    if (r < 18) return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
    return 32'(4 * WORDS) + 32'($urandom_range(0, 255));
  endfunction

  initial begin
    rst_n = 1'b0;
    addr = '0; data_in = '0; we = '0;
    clear_model();

    // Writes during reset must be blocked.
    step(32'h0, 32'hDEAD_BEEF, 1'b1, 32'h4, 32'h1234_0000, 1'b1, "rst_hold");
    step(32'h0, 32'h0, 1'b0, 32'h4, 32'h0, 1'b0, "rst_hold2");
    @(negedge clk);
    rst_n = 1'b1;

    step(32'h0, 32'h0, 1'b0, 32'h4, 32'h0, 1'b0, "reset_read");
    step(32'h0, 32'h1, 1'b1, 32'h4, 32'h0, 1'b0, "wr0");
    step(32'h0, 32'h0, 1'b0, 32'h4, 32'h0, 1'b0, "rd0");
    step(32'h10, 32'h1F1E_003B, 1'b1, 32'h0, 32'h0, 1'b0, "wr10");
    step(32'h10, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "rd10");
    step(32'h0, 32'h0, 1'b0, 32'h10, 32'h0, 1'b0, "alias");
    step(32'h2, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, 1'b0, "misalign_wr");
    step(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "after_misalign");
    step(32'h0, 32'h0, 1'b0, 32'(4 * WORDS), 32'h5555_AAAA, 1'b1, "oob_p1");
    step(32'(4 * WORDS - 4), 32'h7777_0001, 1'b1, 32'(4 * WORDS - 1), 32'h0, 1'b0, "top_word");
    step(32'(4 * WORDS - 4), 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "top_rd");
    step(32'h20, 32'hAAAA_5555, 1'b1, 32'h20, 32'h1234_5678, 1'b1, "collide");
    step(32'h20, 32'h0, 1'b0, 32'h20, 32'h0, 1'b0, "collide_rd");
    step(32'h28, 32'h0BAD_F00D, 1'b1, 32'h2C, 32'h600D_CAFE, 1'b1, "dual_wr");
    step(32'h2C, 32'h0, 1'b0, 32'h28, 32'h0, 1'b0, "dual_rd");
    step(32'h0, 32'h0, 1'b0, 32'h24, 32'hCAFE_BABE, 1'b1, "p1_wr24");
    step(32'h24, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "xport_rd");

    // Mid-run asynchronous reset between edges.
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    #2;
    addr[0] = 32'h10; addr[1] = 32'h20; we = '0;
    #1;
    check_port(0, 32'h10, "async_rst");
    check_port(1, 32'h20, "async_rst");
    step(32'h24, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, "rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h24, 32'h0, 1'b0, 32'h28, 32'h0, 1'b0, "post_rst");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a0, a1;
      a0 = rand_addr();
      a1 = ($urandom_range(0, 5) == 0) ? a0 : rand_addr();
      step(a0, $urandom, 1'($urandom_range(0, 1)),
           a1, $urandom, 1'($urandom_range(0, 1)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
